// File: rtl/fuzz_round_ctrl.sv
// rtl/fuzz_round_ctrl.sv - fuzzing round sequencer: core reset, stall/watchdog irq, round report
module fuzz_round_ctrl #(
    parameter int COV_W       = 30,
    parameter int CNT_W       = 32,
    parameter int STALL_BASE  = 1000,
    parameter int STALL_SHIFT = 19,
    parameter int WDOG_LIMIT  = 50000,
    parameter int DRAIN_LIMIT = 4096,
    parameter int RST_HOLD    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [COV_W-1:0] cov,
    input  logic [63:0]      tohost,
    output logic             core_reset,
    output logic             soft_irq,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [COV_W-1:0] rsp_cov,
    output logic [CNT_W-1:0] rsp_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_REPORT = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam int              PROD_W        = CNT_W + COV_W;
    localparam int              HOLD_W        = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] WDOG_LIM     = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] DRAIN_LIM    = CNT_W'(DRAIN_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_HOLD - 1);
    localparam logic [2:0]      ST_PASS       = 3'd1;
    localparam logic [2:0]      ST_STALL_PASS = 3'd2;
    localparam logic [2:0]      ST_TIMEOUT    = 3'd5;

    state_t state, state_n;

    logic [CNT_W-1:0]  cycles, wdog, stall, drain;
    logic [COV_W-1:0]  pre_cov;
    logic [HOLD_W-1:0] hold_cnt;

    logic [PROD_W-1:0] thresh_wide;
    logic [CNT_W-1:0]  thresh;
    logic              finished, stall_hit, wdog_hit, drain_hit, hold_done;
    logic [2:0]        status_n;
    logic              report_load;
    logic              core_reset_d, soft_irq_d, rsp_valid_d;
    logic              unused_tohost_hi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign unused_tohost_hi = ^tohost[63:1];

    // Threshold grows with coverage; the wide product is clamped rather than wrapped.
    always_comb begin
        thresh_wide = PROD_W'(STALL_BASE) * (PROD_W'(cov >> STALL_SHIFT) + PROD_W'(1));
        thresh      = (|thresh_wide[PROD_W-1:CNT_W]) ? CNT_MAX : thresh_wide[CNT_W-1:0];
    end

    assign finished  = tohost[0];
    assign stall_hit = (stall >= thresh);
    assign wdog_hit  = (wdog >= WDOG_LIM);
    assign drain_hit = (drain >= DRAIN_LIM);
    assign hold_done = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            soft_irq   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_cov    <= '0;
            rsp_cycles <= '0;
        end else begin
            state      <= state_n;
            core_reset <= core_reset_d;
            soft_irq   <= soft_irq_d;
            rsp_valid  <= rsp_valid_d;
            if (report_load) begin
                rsp_status <= status_n;
                rsp_cov    <= cov;
                rsp_cycles <= sat_inc(cycles);
            end
        end
    end

    // tohost is checked ahead of any expiry so a coincident pass is never lost.
    always_comb begin
        state_n  = state;
        status_n = '0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_RUN;
            end
            S_RUN: begin
                if (finished) begin
                    state_n  = S_REPORT;
                    status_n = ST_PASS;
                end else if (stall_hit || wdog_hit) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (finished) begin
                    state_n  = S_REPORT;
                    status_n = ST_STALL_PASS;
                end else if (drain_hit) begin
                    state_n  = S_REPORT;
                    status_n = ST_TIMEOUT;
                end
            end
            S_REPORT: begin
                if (rsp_ready) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (hold_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track state with no lag.
    always_comb begin
        core_reset_d = !((state_n == S_RUN) || (state_n == S_DRAIN));
        soft_irq_d   = (state_n == S_DRAIN);
        rsp_valid_d  = (state_n == S_REPORT);
        report_load  = ((state == S_RUN) || (state == S_DRAIN)) && (state_n == S_REPORT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycles   <= '0;
            wdog     <= '0;
            stall    <= '0;
            drain    <= '0;
            pre_cov  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cycles   <= '0;
                    wdog     <= '0;
                    stall    <= '0;
                    drain    <= '0;
                    pre_cov  <= '0;
                    hold_cnt <= '0;
                end
                S_RUN: begin
                    cycles <= sat_inc(cycles);
                    wdog   <= sat_inc(wdog);
                    if (cov != pre_cov) begin
                        pre_cov <= cov;
                        stall   <= '0;
                    end else begin
                        stall <= sat_inc(stall);
                    end
                end
                S_DRAIN: begin
                    cycles <= sat_inc(cycles);
                    drain  <= sat_inc(drain);
                end
                S_REPORT: begin
                    hold_cnt <= '0;
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                default: begin
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// tb/tb_fuzz_round_ctrl.sv - self-checking bench for fuzz_round_ctrl
module tb_fuzz_round_ctrl;

    localparam int COV_W       = 30;
    localparam int CNT_W       = 32;
    localparam int STALL_BASE  = 1000;
    localparam int STALL_SHIFT = 19;
    localparam int WDOG_LIMIT  = 50000;
    localparam int DRAIN_LIMIT = 4096;
    localparam int RST_HOLD    = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             rsp_ready = 1'b0;
    logic [COV_W-1:0] cov = '0;
    logic [63:0]      tohost = '0;
    logic             core_reset, soft_irq, rsp_valid;
    logic [2:0]       rsp_status;
    logic [COV_W-1:0] rsp_cov;
    logic [CNT_W-1:0] rsp_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fuzz_round_ctrl #(
        .COV_W(COV_W), .CNT_W(CNT_W), .STALL_BASE(STALL_BASE), .STALL_SHIFT(STALL_SHIFT),
        .WDOG_LIMIT(WDOG_LIMIT), .DRAIN_LIMIT(DRAIN_LIMIT), .RST_HOLD(RST_HOLD)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cov(cov), .tohost(tohost),
        .core_reset(core_reset), .soft_irq(soft_irq), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_cov(rsp_cov),
        .rsp_cycles(rsp_cycles)
    );

    // Round-level reference: phase of the round plus elapsed/quiet/irq lengths.
    typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_REPORT, P_HOLD} phase_t;
    phase_t           ph = P_IDLE;
    longint           round_len = 0, quiet = 0, irq_len = 0, th = 0;
    int               hold_left = 0;
    logic [COV_W-1:0] last_cov = '0;
    logic             m_core_reset = 1'b1, m_soft_irq = 1'b0, m_valid = 1'b0;
    logic [2:0]       m_status = '0;
    logic [COV_W-1:0] m_cov = '0;
    longint           m_cycles = 0;
    bit               armed = 1'b0;

    function automatic void end_round(input logic [2:0] s);
        m_status = s;
        m_cov    = cov;
        m_cycles = round_len;
        ph       = P_REPORT;
    endfunction

    initial forever begin
        @(posedge clock);
        if (!reset) begin
            ph = P_IDLE; m_status = '0; m_cov = '0; m_cycles = 0; armed = 1'b1;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    ph = P_RUN; round_len = 0; quiet = 0; irq_len = 0; last_cov = '0;
                end
                P_RUN: begin
                    round_len++;
                    th = longint'(STALL_BASE) * (longint'(cov >> STALL_SHIFT) + 1);
                    if (tohost[0]) end_round(3'd1);
                    else if (quiet >= th || round_len - 1 >= WDOG_LIMIT) ph = P_DRAIN;
                    if (cov != last_cov) begin last_cov = cov; quiet = 0; end
                    else quiet++;
                end
                P_DRAIN: begin
                    round_len++;
                    if (tohost[0]) end_round(3'd2);
                    else if (irq_len >= DRAIN_LIMIT) end_round(3'd5);
                    irq_len++;
                end
                P_REPORT: if (rsp_ready) begin ph = P_HOLD; hold_left = RST_HOLD; end
                P_HOLD: begin
                    hold_left--;
                    if (hold_left == 0) ph = P_IDLE;
                end
                default: ph = P_IDLE;
            endcase
        end
        m_core_reset = !(ph == P_RUN || ph == P_DRAIN);
        m_soft_irq   = (ph == P_DRAIN);
        m_valid      = (ph == P_REPORT);
    end

    initial forever begin
        @(negedge clock);
        if (armed) begin
            vectors++;
            if (core_reset !== m_core_reset || soft_irq !== m_soft_irq || rsp_valid !== m_valid ||
                rsp_status !== m_status || rsp_cov !== m_cov || rsp_cycles !== CNT_W'(m_cycles)) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL cycle_cmp t=%0t got cr=%b irq=%b v=%b st=%0d cov=%h cyc=%0d expected cr=%b irq=%b v=%b st=%0d cov=%h cyc=%0d",
                             $time, core_reset, soft_irq, rsp_valid, rsp_status, rsp_cov, rsp_cycles,
                             m_core_reset, m_soft_irq, m_valid, m_status, m_cov, m_cycles);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic begin_round;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < budget) begin
            @(negedge clock); waited++;
        end
        if (rsp_valid !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL valid_timeout: got rsp_valid=%b after %0d cycles, expected 1", rsp_valid, waited);
        end
    endtask

    task automatic wait_irq(input int budget, output int waited);
        waited = 0;
        while (soft_irq !== 1'b1 && waited < budget) begin
            @(negedge clock); waited++;
        end
    endtask

    task automatic accept;
        @(negedge clock); rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int n, w;
        tick(3);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_soft_irq", soft_irq, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_cycles", rsp_cycles, 0);
        reset = 1'b1;
        tick(2);

        // plain pass after 100 clean cycles
        begin_round; tick(100); tohost = 64'd1;
        wait_valid(10, w); tohost = '0;
        chk("pass_status", rsp_status, 1);
        chk("pass_cycles", rsp_cycles, 101);
        chk("pass_core_reset", core_reset, 1);
        accept; tick(10);

        // stall at threshold 1000, then pass inside the drain window
        cov = 30'd5;
        begin_round; wait_irq(1100, n);
        chk("stall_irq_latency", n, 1002);
        tick(50); tohost = 64'd1;
        wait_valid(5, w); tohost = '0;
        chk("stall_status", rsp_status, 2);
        chk("stall_cycles", rsp_cycles, 1053);
        chk("stall_cov", rsp_cov, 5);
        accept; tick(10);

        // scaled threshold: cov>>19 = 2 gives 3000
        cov = 30'h100000;
        begin_round; wait_irq(3100, n);
        chk("scaled_irq_latency", n, 3002);
        tohost = 64'd1;
        wait_valid(5, w); tohost = '0;
        chk("scaled_status", rsp_status, 2);
        chk("scaled_cycles", rsp_cycles, 3003);
        chk("scaled_cov", rsp_cov, 64'h100000);
        accept; tick(10);

        // busy coverage never stalls; watchdog trips instead
        cov = 30'd1;
        begin_round;
        n = 0;
        while (soft_irq !== 1'b1 && n < 50100) begin
            @(negedge clock); n++;
            if (n % 10 == 0) cov = cov ^ 30'd3;
        end
        chk("wdog_irq_latency", n, 50001);
        tick(5); tohost = 64'd1;
        wait_valid(5, w); tohost = '0;
        chk("wdog_status", rsp_status, 2);
        chk("wdog_cycles", rsp_cycles, 50007);
        accept; tick(10);

        // drain timeout, back-pressured report, then hold spacing with start held
        cov = 30'd5;
        begin_round; wait_valid(6000, w);
        chk("timeout_latency", w, 5099);
        chk("timeout_status", rsp_status, 5);
        chk("timeout_cycles", rsp_cycles, 5099);
        chk("timeout_irq_off", soft_irq, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("report_stable", {rsp_valid, rsp_status, rsp_cycles}, {1'b1, 3'd5, 32'd5099});
        end
        @(negedge clock); rsp_ready = 1'b1; start = 1'b1;
        n = 0;
        while (core_reset !== 1'b0 && n < 20) begin
            @(negedge clock); rsp_ready = 1'b0; n++;
            if (n == 1) chk("valid_drop", rsp_valid, 0);
        end
        chk("hold_spacing", n, 10);
        start = 1'b0;

        // pass and stall expiry in the same cycle: pass wins
        tick(1001); tohost = 64'd1;
        wait_valid(5, w); tohost = '0;
        chk("tie_status", rsp_status, 1);
        chk("tie_cycles", rsp_cycles, 1002);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        accept; tick(10);

        // tohost held high through IDLE is ignored until the round starts
        tohost = 64'd1; tick(5);
        begin_round; wait_valid(5, w); tohost = '0;
        chk("early_tohost_latency", w, 1);
        chk("early_tohost_cycles", rsp_cycles, 1);
        accept; tick(10);

        // reset in the middle of DRAIN
        cov = '0;
        begin_round; wait_irq(1100, n);
        chk("zero_cov_irq_latency", n, 1001);
        tick(3); reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_irq", soft_irq, 0);
        chk("mid_rst_core_reset", core_reset, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_cycles", rsp_cycles, 0);
        reset = 1'b1; tick(2);

        begin_round; tick(4); tohost = 64'd1;
        wait_valid(5, w); tohost = '0;
        chk("recover_cycles", rsp_cycles, 5);
        accept; tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fuzz_round_ctrl.md
# fuzz_round_ctrl

Synthesizable round sequencer for the co-simulation fuzzing harness, sitting between the SoC under test and the host-side fuzz manager. It holds the core in reset between rounds and releases it on a host start request. During a round it watches the coverage summary and the `tohost` word, and raises a software interrupt when coverage stalls or the round watchdog expires. Each round ends with a status/coverage/cycle report delivered to the host through a valid/ready handshake.

## Interface
Parameters:
- `COV_W`, 30, width of coverage summary input
- `CNT_W`, 32, width of stall, watchdog and cycle counters
- `STALL_BASE`, 1000, base stall threshold in cycles
- `STALL_SHIFT`, 19, coverage right-shift used to scale the stall threshold
- `WDOG_LIMIT`, 50000, round watchdog limit in cycles
- `DRAIN_LIMIT`, 4096, cycles allowed after the interrupt before declaring a timeout
- `RST_HOLD`, 8, cycles `core_reset` is held after a report is accepted

Ports:
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  host pulse: testcase loaded, begin round
- `cov`  in  COV_W  coverage summary from SoC
- `tohost`  in  64  tohost word; bit 0 means test finished
- `core_reset`  out  1  active-high reset to the core
- `soft_irq`  out  1  drives core msip
- `rsp_valid`  out  1  round report valid
- `rsp_ready`  in  1  host accepts report
- `rsp_status`  out  3  1 = PASS, 2 = STALL_PASS, 5 = TIMEOUT
- `rsp_cov`  out  COV_W  coverage at round end
- `rsp_cycles`  out  CNT_W  cycles spent in RUN plus DRAIN

## Operation
- States:
  - IDLE: `core_reset`=1. `start` → RUN. Clear all counters and `pre_cov`.
  - RUN: `core_reset`=0. Every cycle, increment `cycles` and `wdog`.
    - If `cov != pre_cov`, set `pre_cov <= cov` and `stall <= 0`; otherwise `stall++`.
    - `tohost[0]` → REPORT with status 1.
    - Otherwise, `stall >= thresh` or `wdog >= WDOG_LIMIT` → DRAIN.
  - DRAIN: `soft_irq`=1. `cycles` keeps counting and `drain` counts.
    - `tohost[0]` → REPORT with status 2.
    - `drain >= DRAIN_LIMIT` → REPORT with status 5.
  - REPORT: `core_reset`=1, `soft_irq`=0, `rsp_valid`=1. The `rsp_*` fields are frozen.
    - On `rsp_valid && rsp_ready` → HOLD.
  - HOLD: `core_reset`=1 for exactly `RST_HOLD` cycles → IDLE.
- Stall threshold: `thresh = STALL_BASE * ((cov >> STALL_SHIFT) + 1)`.
  - Computed in CNT_W+COV_W bits.
  - Saturates to all-ones in CNT_W if it overflows.
- Counters saturate at all-ones and never wrap.
- Precedence within one cycle:
  - `tohost[0]` beats stall/watchdog expiry, so a round whose pass and stall coincide reports PASS (1).
  - In DRAIN, `tohost[0]` beats `DRAIN_LIMIT` expiry, so the status is 2.
- `start` is ignored outside IDLE. `rsp_ready` is ignored outside REPORT.
- `tohost` is sampled only in RUN and DRAIN. A `tohost[0]` that stays high in IDLE, REPORT or HOLD is ignored.

## Timing
- All outputs are registered; every state change appears on outputs one cycle after the deciding edge.
- Reset (`reset`=0 at a rising edge) → state IDLE next cycle, from any state including mid-round and mid-handshake.
  - Outputs after reset: `core_reset`=1, `soft_irq`=0, `rsp_valid`=0, `rsp_status`=0, `rsp_cov`=0, `rsp_cycles`=0.
  - Any pending report is dropped.
- `start` sampled at edge N → `core_reset` is 0 from cycle N+1.
- `tohost[0]` sampled at edge N in RUN → `rsp_valid`=1 and `core_reset`=1 at N+1.
- Report fields:
  - `rsp_cycles` is the number of RUN+DRAIN cycles, inclusive of the deciding cycle.
  - `rsp_cov` is `cov` sampled at the deciding edge.
- `rsp_valid` stays high and the fields stay stable until accepted; deassertion happens the cycle after acceptance.
- Minimum spacing from report acceptance to the next round: `RST_HOLD`+1 cycles before IDLE accepts `start`.

## Test plan
- Pass: `start`, `cov` constant 0, `tohost`=1 after 100 cycles → status 1, `rsp_cycles`=101, `soft_irq` never asserted.
- Stall: `start`, `cov` fixed at 5 (thresh 1000) → `soft_irq` rises after `stall` reaches 1000; `tohost`=1 50 cycles later → status 2.
- Scaled threshold and watchdog:
  - With `cov`=0x100000 (shift gives 2, thresh 3000), no irq before 3000 stalled cycles.
  - Toggling `cov` every 10 cycles → irq at `wdog`=50000.
- Timeout: stall into DRAIN with no `tohost` → status 5 after `DRAIN_LIMIT`. Hold `rsp_ready`=0 for 20 cycles → fields stable; then accept → `core_reset` held 8 cycles, then IDLE.
- Simultaneous pass and stall expiry in the same cycle → status 1.
- `reset`=0 mid-DRAIN → `soft_irq`=0, `core_reset`=1, `rsp_valid`=0 next cycle.
